// File: rtl/cache_axi_master.sv
// Memory-side AXI4-Lite master for the cache: one single-beat transaction at a
// time, write-back ahead of refill so a dirty eviction lands before the new fetch.
module cache_axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // cache-side request/response
    input  logic                      mem_rd_req,
    input  logic [ADDR_WIDTH-1:0]     mem_araddr,
    input  logic                      mem_wr_req,
    input  logic [ADDR_WIDTH-1:0]     mem_awaddr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_rd_ack,
    output logic                      mem_wr_ack,
    output logic                      mem_err,
    // AXI4-Lite read address / data
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    // AXI4-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic ack_cycle;
    logic wr_issued;

    logic [ADDR_WIDTH-1:0] araddr_nxt, awaddr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;
    logic                  arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
    logic                  rd_ack_nxt, wr_ack_nxt, err_nxt;

    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid  & m_rready;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;
    assign b_hs  = m_bvalid  & m_bready;

    // A request that was just acked is still high this cycle; ignore it so it is not served twice.
    assign ack_cycle = mem_rd_ack | mem_wr_ack;

    // AW and W complete independently; each is done if it handshakes now or already has.
    assign wr_issued = (aw_hs | ~m_awvalid) & (w_hs | ~m_wvalid);

    // Only full-word write-backs are ever issued.
    assign m_wstrb = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!ack_cycle) begin
                    if (mem_wr_req) begin
                        state_nxt = WR_REQ;
                    end else if (mem_rd_req) begin
                        state_nxt = RD_ADDR;
                    end
                end
            end
            WR_REQ:  if (wr_issued) state_nxt = WR_RESP;
            WR_RESP: if (b_hs)      state_nxt = IDLE;
            RD_ADDR: if (ar_hs)     state_nxt = RD_DATA;
            RD_DATA: if (r_hs)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        araddr_nxt  = m_araddr;
        arvalid_nxt = m_arvalid;
        rready_nxt  = m_rready;
        awaddr_nxt  = m_awaddr;
        awvalid_nxt = m_awvalid;
        wdata_nxt   = m_wdata;
        wvalid_nxt  = m_wvalid;
        bready_nxt  = m_bready;
        rdata_nxt   = mem_rdata;
        rd_ack_nxt  = 1'b0;
        wr_ack_nxt  = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (!ack_cycle) begin
                    if (mem_wr_req) begin
                        awaddr_nxt  = mem_awaddr;
                        wdata_nxt   = mem_wdata;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else if (mem_rd_req) begin
                        araddr_nxt  = mem_araddr;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs)     awvalid_nxt = 1'b0;
                if (w_hs)      wvalid_nxt  = 1'b0;
                if (wr_issued) bready_nxt  = 1'b1;
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_nxt = 1'b0;
                    wr_ack_nxt = 1'b1;
                    err_nxt    = (m_bresp != 2'b00);
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                end
            end
            RD_DATA: begin
                // Data is returned even on an error response; the controller decides what to do with it.
                if (r_hs) begin
                    rdata_nxt  = m_rdata;
                    rready_nxt = 1'b0;
                    rd_ack_nxt = 1'b1;
                    err_nxt    = (m_rresp != 2'b00);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_araddr   <= '0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
            m_awaddr   <= '0;
            m_awvalid  <= 1'b0;
            m_wdata    <= '0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            mem_rdata  <= '0;
            mem_rd_ack <= 1'b0;
            mem_wr_ack <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            m_araddr   <= araddr_nxt;
            m_arvalid  <= arvalid_nxt;
            m_rready   <= rready_nxt;
            m_awaddr   <= awaddr_nxt;
            m_awvalid  <= awvalid_nxt;
            m_wdata    <= wdata_nxt;
            m_wvalid   <= wvalid_nxt;
            m_bready   <= bready_nxt;
            mem_rdata  <= rdata_nxt;
            mem_rd_ack <= rd_ack_nxt;
            mem_wr_ack <= wr_ack_nxt;
            mem_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_cache_axi_master.sv
// Bench for cache_axi_master: AXI4-Lite slave model with programmable stalls,
// scoreboard of expected acks, vector table plus directed corner sequences.
module tb_cache_axi_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_rd_req = 1'b0;
    logic [AW-1:0] mem_araddr = '0;
    logic          mem_wr_req = 1'b0;
    logic [AW-1:0] mem_awaddr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_rd_ack, mem_wr_ack, mem_err;
    logic [AW-1:0] m_araddr;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = 2'b00;
    logic          m_rvalid = 1'b0;
    logic          m_rready;
    logic [AW-1:0] m_awaddr;
    logic          m_awvalid;
    logic          m_awready = 1'b0;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic          m_wvalid;
    logic          m_wready = 1'b0;
    logic [1:0]    m_bresp = 2'b00;
    logic          m_bvalid = 1'b0;
    logic          m_bready;

    cache_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .mem_rd_req(mem_rd_req), .mem_araddr(mem_araddr),
        .mem_wr_req(mem_wr_req), .mem_awaddr(mem_awaddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rd_ack(mem_rd_ack), .mem_wr_ack(mem_wr_ack), .mem_err(mem_err),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Slave memory contents: a fixed pattern, with one overridable location.
    logic          ovr_en = 1'b0;
    logic [AW-1:0] ovr_addr = '0;
    logic [DW-1:0] ovr_data = '0;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Slave configuration for the next transaction
    int       cfg_ar = 0, cfg_aw = 0, cfg_w = 0, cfg_r = 0, cfg_b = 0;
    logic [1:0] cfg_rresp = 2'b00, cfg_bresp = 2'b00;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;
    exp_t sb[$];
    exp_t sb_e;

    // Slave state
    bit            ar_act, aw_act, w_act, aw_got, w_got, r_pend, b_act;
    int            ar_st, aw_st, w_st, r_cnt, b_cnt;
    logic [AW-1:0] r_addr, cap_awaddr;
    logic [DW-1:0] cap_wdata;
    logic          arv_q, arr_q, awv_q, awr_q, wv_q, wr_q, rv_q, rr_q, bv_q, br_q;
    logic [AW-1:0] ara_q, awa_q;
    logic [DW-1:0] wd_q;

    initial begin : bus_model
        forever begin
            @(negedge clk);
            if (!rst) begin
                ar_act = 0; aw_act = 0; w_act = 0; aw_got = 0; w_got = 0; r_pend = 0; b_act = 0;
                m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
                arv_q = 0; arr_q = 0; awv_q = 0; awr_q = 0; wv_q = 0; wr_q = 0;
                rv_q = 0; rr_q = 0; bv_q = 0; br_q = 0;
                ara_q = '0; awa_q = '0; wd_q = '0;
                continue;
            end
            // Valid/address/data must stay put while the slave stalls.
            if (arv_q && !arr_q) chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, ara_q});
            if (awv_q && !awr_q) chk("aw_hold", {m_awvalid, m_awaddr}, {1'b1, awa_q});
            if (wv_q && !wr_q)   chk("w_hold",  {m_wvalid, m_wdata},  {1'b1, wd_q});

            // Handshakes that completed at the preceding rising edge
            if (rv_q && rr_q) r_pend = 0;
            if (arv_q && arr_q) begin r_pend = 1; r_addr = ara_q; r_cnt = cfg_r; ar_act = 0; end
            if (awv_q && awr_q) begin aw_got = 1; cap_awaddr = awa_q; aw_act = 0; end
            if (wv_q && wr_q)   begin w_got = 1; cap_wdata = wd_q; w_act = 0; end
            if (bv_q && br_q)   begin b_act = 0; aw_got = 0; w_got = 0; end
            if (aw_got && w_got && !b_act) begin b_act = 1; b_cnt = cfg_b; end

            // Scoreboard
            if (mem_rd_ack || mem_wr_ack) begin
                chk("both_acks", mem_rd_ack & mem_wr_ack, 0);
                chk("ack_expected", sb.size() == 0, 0);
                if (sb.size() != 0) begin
                    sb_e = sb.pop_front();
                    chk("ack_kind", mem_wr_ack, sb_e.wr);
                    chk("mem_err", mem_err, sb_e.err);
                    if (sb_e.wr) begin
                        chk("wr_awaddr", cap_awaddr, sb_e.addr);
                        chk("wr_wdata", cap_wdata, sb_e.data);
                    end else begin
                        chk("rd_rdata", mem_rdata, sb_e.data);
                    end
                end
            end else if (mem_err) begin
                chk("err_without_ack", mem_err, 0);
            end

            // Drive slave outputs for the coming edge
            if (m_arvalid) begin
                if (!ar_act) begin ar_act = 1; ar_st = cfg_ar; end
                if (ar_st > 0) begin m_arready = 0; ar_st--; end else m_arready = 1;
            end else m_arready = 0;
            if (m_awvalid) begin
                if (!aw_act) begin aw_act = 1; aw_st = cfg_aw; end
                if (aw_st > 0) begin m_awready = 0; aw_st--; end else m_awready = 1;
            end else m_awready = 0;
            if (m_wvalid) begin
                if (!w_act) begin w_act = 1; w_st = cfg_w; end
                if (w_st > 0) begin m_wready = 0; w_st--; end else m_wready = 1;
            end else m_wready = 0;
            if (r_pend) begin
                if (r_cnt > 0) begin m_rvalid = 0; r_cnt--; end
                else begin m_rvalid = 1; m_rdata = rd_model(r_addr); m_rresp = cfg_rresp; end
            end else m_rvalid = 0;
            if (b_act) begin
                if (b_cnt > 0) begin m_bvalid = 0; b_cnt--; end
                else begin m_bvalid = 1; m_bresp = cfg_bresp; end
            end else m_bvalid = 0;

            arv_q = m_arvalid; ara_q = m_araddr; arr_q = m_arready;
            awv_q = m_awvalid; awa_q = m_awaddr; awr_q = m_awready;
            wv_q = m_wvalid;   wd_q = m_wdata;   wr_q = m_wready;
            rv_q = m_rvalid;   rr_q = m_rready;
            bv_q = m_bvalid;   br_q = m_bready;
        end
    end

    task automatic set_cfg(input int ar, input int aw, input int w, input int r, input int b,
                           input logic [1:0] rresp, input logic [1:0] bresp);
        cfg_ar = ar; cfg_aw = aw; cfg_w = w; cfg_r = r; cfg_b = b;
        cfg_rresp = rresp; cfg_bresp = bresp;
    endtask

    task automatic push_exp(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit e);
        exp_t x;
        x.wr = wr; x.addr = a; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    // Waits for the ack of the given kind; latency counts rising edges from the request edge.
    task automatic wait_ack(input bit wr, input int exp_lat, input bit drop, input string nm);
        int lat;
        bit seen;
        seen = 0;
        lat = 0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (wr ? mem_wr_ack : mem_rd_ack) begin
                seen = 1;
                lat = c;
            end
        end
        chk({nm, "_ack_seen"}, seen, 1);
        if (seen && exp_lat >= 0) chk({nm, "_latency"}, lat, exp_lat);
        if (drop) begin
            @(negedge clk);
            if (wr) mem_wr_req = 0; else mem_rd_req = 0;
        end
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            ar, aw, w, r, b;
        logic [1:0]    resp;
        bit            err;
        int            lat;
    } vec_t;
    vec_t vt[7];

    int acks_seen;
    logic [AW-1:0] a;

    initial begin
        ovr_en = 1; ovr_addr = 32'h0000_1004; ovr_data = 32'hDEAD_BEEF;
        //        wr  addr           data                       ar aw w  r  b  resp   err lat
        vt[0] = '{0, 32'h0000_1004, 32'hDEAD_BEEF,             0, 0, 0, 0, 0, 2'b00, 0, 3};
        vt[1] = '{0, 32'h0000_1100, rd_model(32'h0000_1100),   1, 0, 0, 2, 0, 2'b00, 0, 6};
        vt[2] = '{1, 32'h0000_2000, 32'h0000_AA55,             0, 0, 3, 0, 1, 2'b00, 0, 7};
        vt[3] = '{1, 32'h0000_2010, 32'hCAFE_F00D,             0, 0, 0, 0, 0, 2'b11, 1, 3};
        vt[4] = '{0, 32'h0000_1200, rd_model(32'h0000_1200),   0, 0, 0, 0, 0, 2'b10, 1, 3};
        vt[5] = '{1, 32'h0000_2020, 32'h0BAD_F00D,             0, 1, 1, 0, 0, 2'b00, 0, 4};
        vt[6] = '{0, 32'h0000_1300, rd_model(32'h0000_1300),   0, 0, 0, 1, 0, 2'b00, 0, 4};

        repeat (2) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_acks_err", {mem_rd_ack, mem_wr_ack, mem_err}, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_awaddr", m_awaddr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_wstrb", m_wstrb, 4'hF);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            if (vt[i].wr) set_cfg(vt[i].ar, vt[i].aw, vt[i].w, vt[i].r, vt[i].b, 2'b00, vt[i].resp);
            else          set_cfg(vt[i].ar, vt[i].aw, vt[i].w, vt[i].r, vt[i].b, vt[i].resp, 2'b00);
            @(negedge clk);
            if (vt[i].wr) begin
                mem_wr_req = 1; mem_awaddr = vt[i].addr; mem_wdata = vt[i].data;
            end else begin
                mem_rd_req = 1; mem_araddr = vt[i].addr;
            end
            push_exp(vt[i].wr, vt[i].addr, vt[i].data, vt[i].err);
            wait_ack(vt[i].wr, vt[i].lat, 1, $sformatf("vec%0d", i));
        end

        // Write with AW stalled two cycles, W immediate: W completes first, AW holds.
        set_cfg(0, 2, 0, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        mem_wr_req = 1; mem_awaddr = 32'h0000_2008; mem_wdata = 32'h1234_5678;
        push_exp(1, 32'h0000_2008, 32'h1234_5678, 0);
        @(posedge clk); #1;
        chk("awstall_valids_e0", {m_awvalid, m_wvalid}, 2'b11);
        @(posedge clk); #1;
        chk("awstall_valids_e1", {m_awvalid, m_wvalid}, 2'b10);
        chk("awstall_awaddr", m_awaddr, 32'h0000_2008);
        wait_ack(1, 3, 1, "awstall");

        // Simultaneous write and read: write first, read only after the ack cycle.
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        mem_wr_req = 1; mem_awaddr = 32'h0000_3000; mem_wdata = 32'h5555_AAAA;
        mem_rd_req = 1; mem_araddr = 32'h0000_3100;
        push_exp(1, 32'h0000_3000, 32'h5555_AAAA, 0);
        push_exp(0, 32'h0000_3100, rd_model(32'h0000_3100), 0);
        @(posedge clk); #1;
        chk("both_req_ar_idle", m_arvalid, 0);
        wait_ack(1, 2, 1, "both_wr");
        @(posedge clk); #1;
        chk("both_req_ar_ackcycle", m_arvalid, 0);
        wait_ack(0, 3, 1, "both_rd");

        // Request held through its ack cycle must not be served twice.
        @(negedge clk);
        mem_rd_req = 1; mem_araddr = 32'h0000_3200;
        push_exp(0, 32'h0000_3200, rd_model(32'h0000_3200), 0);
        wait_ack(0, 3, 0, "hold");
        @(posedge clk); #1;
        chk("hold_no_reissue_a", m_arvalid, 0);
        @(negedge clk);
        mem_rd_req = 0;
        @(posedge clk); #1;
        chk("hold_no_reissue_b", m_arvalid, 0);

        // Reset while waiting for read data
        set_cfg(0, 0, 0, 6, 0, 2'b00, 2'b00);
        @(negedge clk);
        mem_rd_req = 1; mem_araddr = 32'h0000_5000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid_in_rd_data", {m_arvalid, m_rready}, 2'b01);
        #2 rst = 0;
        #1;
        chk("rstmid_rready", m_rready, 0);
        chk("rstmid_araddr", m_araddr, 0);
        chk("rstmid_rdata", mem_rdata, 0);
        chk("rstmid_acks", {mem_rd_ack, mem_wr_ack, mem_err}, 0);
        mem_rd_req = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        acks_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mem_rd_ack || mem_wr_ack) acks_seen++;
        end
        chk("rstmid_no_ack", acks_seen, 0);
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        mem_rd_req = 1; mem_araddr = 32'h0000_5004;
        push_exp(0, 32'h0000_5004, rd_model(32'h0000_5004), 0);
        wait_ack(0, 3, 1, "post_rst");

        // 256 back-to-back reads with random slave stalls
        for (int i = 0; i < 256; i++) begin
            set_cfg($urandom_range(0, 3), 0, 0, $urandom_range(0, 3), 0, 2'b00, 2'b00);
            a = 32'h0000_8000 + 32'(i) * 4;
            @(negedge clk);
            mem_rd_req = 1; mem_araddr = a;
            push_exp(0, a, rd_model(a), 0);
            wait_ack(0, 3 + cfg_ar + cfg_r, 1, "burst");
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
